// File: rtl/dac_sched_pkg.sv
// dac_sched_pkg
//   Shared definitions for the DAC sample scheduler.
//   - sched_state_t : playback FSM states (IDLE, PRIME, RUN)
//   - MIDSCALE()    : midscale DAC code for a given code width, used as the
//                     reset value so the analog output parks at mid-rail.
package dac_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } sched_state_t;

  function automatic int unsigned MIDSCALE(input int unsigned width);
    return 32'd1 << (width - 32'd1);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo
//   Synchronous single-clock FIFO holding DAC samples between the CPU and
//   the playback scheduler.
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset, empties the FIFO
//   flush    : synchronous clear; wins over a same-cycle push and pop
//   push     : write wr_data (ignored when full)
//   wr_data  : sample to store
//   pop      : advance the read pointer (ignored when empty)
//   rd_data  : current head entry (valid when !empty)
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : current occupancy, 0..DEPTH
module sample_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the registered count, so a push is refused when
  // full even if a pop frees a slot in the same cycle.
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/dac_sample_sched.sv
// dac_sample_sched
//   Paces CPU-supplied DAC samples onto the DAC at a fixed sample period.
//   Samples are buffered in a FIFO; playback starts once the FIFO is half
//   full (PRIME), then one sample is moved to the DAC code register every
//   max(period,1) clock cycles (RUN). Running dry sets a sticky underrun
//   flag, bumps a saturating counter and drops back to PRIME to refill.
//
// Ports
//   clk            : clock, rising edge
//   rst            : asynchronous active-high reset
//   enable         : 1 = playback allowed, 0 = go to IDLE (FIFO retained)
//   flush          : synchronous FIFO clear
//   period         : clk cycles per sample (0 behaves as 1)
//   in_data        : sample from the CPU
//   in_valid       : in_data valid; pushed when in_ready is also high
//   in_ready       : FIFO not full
//   code           : current DAC code (midscale after reset)
//   code_load      : one-cycle strobe, code was just updated
//   underrun       : sticky, FIFO was empty at a sample tick
//   underrun_cnt   : saturating count of underruns
//   clear_underrun : clears underrun and underrun_cnt
//   fifo_count     : FIFO occupancy
module dac_sample_sched
  import dac_sched_pkg::*;
#(
  parameter int CODE_WIDTH   = 10,
  parameter int DEPTH        = 8,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      flush,
  input  logic [PERIOD_WIDTH-1:0]   period,
  input  logic [CODE_WIDTH-1:0]     in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CODE_WIDTH-1:0]     code,
  output logic                      code_load,
  output logic                      underrun,
  output logic [7:0]                underrun_cnt,
  input  logic                      clear_underrun,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CODE_WIDTH-1:0]   MID_CODE    = CODE_WIDTH'(MIDSCALE(CODE_WIDTH));
  localparam logic [CW-1:0]           PRIME_LEVEL = CW'(DEPTH / 2);
  localparam logic [PERIOD_WIDTH-1:0] ONE         = PERIOD_WIDTH'(1);

  sched_state_t            state;
  sched_state_t            state_next;
  logic [PERIOD_WIDTH-1:0] timer;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic [PERIOD_WIDTH-1:0] period_lim;
  logic                    at_last;
  logic                    tick;
  logic                    pop_req;
  logic                    underrun_evt;
  logic                    push;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CODE_WIDTH-1:0]   head;

  sample_fifo #(
    .WIDTH (CODE_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (push),
    .wr_data (in_data),
    .pop     (pop_req),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  // period is latched into period_q, so the CPU may rewrite it at any time
  // without producing a short or long sample mid-interval. A latched 0 is
  // treated as 1, i.e. a tick every cycle.
  assign period_lim = (period_q == '0) ? ONE : period_q;
  assign at_last    = (timer == (period_lim - ONE));

  // Ticks are only meaningful while running; dropping enable suppresses the
  // tick of that cycle so nothing is consumed on the way to IDLE.
  assign tick         = (state == RUN) && enable && at_last;
  assign underrun_evt = tick && fifo_empty;

  // A flush in the tick cycle empties the FIFO instead of consuming the head,
  // so no code update is made for that tick.
  assign pop_req = tick && !fifo_empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = PRIME;
        PRIME:   if (fifo_count >= PRIME_LEVEL) state_next = RUN;
        RUN:     if (underrun_evt) state_next = PRIME;
        default: state_next = IDLE;
      endcase
    end
  end

  // The timer only runs in RUN, so every entry to RUN starts a full period.
  // period_q is refreshed at each wrap and whenever PRIME is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer    <= '0;
      period_q <= '0;
    end else begin
      if (state != RUN || at_last) begin
        timer <= '0;
      end else begin
        timer <= timer + ONE;
      end
      if ((state_next == PRIME && state != PRIME) || (state == RUN && at_last)) begin
        period_q <= period;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code      <= MID_CODE;
      code_load <= 1'b0;
    end else begin
      code_load <= pop_req;
      if (pop_req) begin
        code <= head;
      end
    end
  end

  // A clear coinciding with a new underrun must leave that underrun visible,
  // hence the flag and count restart from the event rather than from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun     <= 1'b0;
      underrun_cnt <= 8'd0;
    end else if (clear_underrun) begin
      underrun     <= underrun_evt;
      underrun_cnt <= underrun_evt ? 8'd1 : 8'd0;
    end else if (underrun_evt) begin
      underrun <= 1'b1;
      if (underrun_cnt != 8'hFF) begin
        underrun_cnt <= underrun_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dac_sample_sched.sv
// tb_dac_sample_sched
//   Directed self-checking bench for dac_sample_sched at default parameters
//   (CODE_WIDTH=10, DEPTH=8, PERIOD_WIDTH=16).
module tb_dac_sample_sched;
  import dac_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        flush;
  logic [15:0] period;
  logic [9:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  code;
  logic        code_load;
  logic        underrun;
  logic [7:0]  underrun_cnt;
  logic        clear_underrun;
  logic [3:0]  fifo_count;

  int checks   = 0;
  int failures = 0;

  dac_sample_sched dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .flush          (flush),
    .period         (period),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .code           (code),
    .code_load      (code_load),
    .underrun       (underrun),
    .underrun_cnt   (underrun_cnt),
    .clear_underrun (clear_underrun),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are read 1 time unit after the rising edge
  // and inputs changed here take effect at the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Push n consecutive sample values starting at first, one per cycle.
  task automatic applyStimulus(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 10'(first + i);
      step();
    end
    in_valid = 1'b0;
  endtask

  // Step until code_load is seen or the budget runs out; n is the number of
  // edges taken (equals limit on timeout, which then fails the gap check).
  task automatic wait_load(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!code_load && n < limit);
  endtask

  // From PRIME with an empty FIFO and a latched period of 0: four pushes
  // reach the prime level, a flush on the PRIME->RUN edge empties the FIFO,
  // and the first RUN tick underruns. clr is applied on the underrun edge.
  task automatic force_underrun(input logic clr);
    applyStimulus(0, 4);
    flush = 1'b1;
    step();
    flush          = 1'b0;
    clear_underrun = clr;
    step();
    clear_underrun = 1'b0;
  endtask

  initial begin
    int n;

    rst            = 1'b1;
    enable         = 1'b0;
    flush          = 1'b0;
    period         = 16'd4;
    in_data        = '0;
    in_valid       = 1'b0;
    clear_underrun = 1'b0;

    // Reset state
    step();
    step();
    checkOutput("rst_code", 32'(code), 32'd512);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);
    checkOutput("rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_code_load", 32'(code_load), 32'd0);
    checkOutput("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    step();
    checkOutput("idle_after_rst", 32'(dut.state), 32'(IDLE));

    // Playback at period 4: fill, confirm full refuses a push, then play 1..8
    applyStimulus(1, 8);
    checkOutput("full_count", 32'(fifo_count), 32'd8);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 10'd99;
    step();
    in_valid = 1'b0;
    checkOutput("full_push_refused", 32'(fifo_count), 32'd8);
    enable = 1'b1;
    wait_load(20, n);
    checkOutput("first_load_latency", 32'(n), 32'd6);
    checkOutput("play_code_1", 32'(code), 32'd1);
    for (int k = 2; k <= 8; k++) begin
      wait_load(20, n);
      checkOutput("play_gap", 32'(n), 32'd4);
      checkOutput("play_code", 32'(code), 32'(k));
    end
    repeat (4) step();
    checkOutput("play_underrun", 32'(underrun), 32'd1);
    checkOutput("play_underrun_cnt", 32'(underrun_cnt), 32'd1);
    checkOutput("play_code_held", 32'(code), 32'd8);
    checkOutput("play_no_load", 32'(code_load), 32'd0);
    checkOutput("play_state_prime", 32'(dut.state), 32'(PRIME));

    // Period 0: one load per cycle; push while full during a pop is refused
    enable         = 1'b0;
    clear_underrun = 1'b1;
    step();
    clear_underrun = 1'b0;
    checkOutput("clr_underrun", 32'(underrun), 32'd0);
    checkOutput("clr_underrun_cnt", 32'(underrun_cnt), 32'd0);
    checkOutput("disable_idle", 32'(dut.state), 32'(IDLE));
    period = 16'd0;
    applyStimulus(10, 8);
    enable = 1'b1;
    step();
    step();
    checkOutput("p0_state_run", 32'(dut.state), 32'(RUN));
    checkOutput("p0_in_ready_full", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 10'd99;
    step();
    in_valid = 1'b0;
    checkOutput("p0_push_pop_full", 32'(fifo_count), 32'd7);
    checkOutput("p0_code_first", 32'(code), 32'd10);
    checkOutput("p0_load_first", 32'(code_load), 32'd1);
    for (int k = 11; k <= 17; k++) begin
      wait_load(5, n);
      checkOutput("p0_gap", 32'(n), 32'd1);
      checkOutput("p0_code", 32'(code), 32'(k));
    end
    step();
    checkOutput("p0_underrun", 32'(underrun), 32'd1);
    checkOutput("p0_underrun_cnt", 32'(underrun_cnt), 32'd1);
    checkOutput("p0_code_held", 32'(code), 32'd17);

    // Flush mid-RUN with 5 entries, then the next tick underruns
    enable = 1'b0;
    step();
    period = 16'd8;
    applyStimulus(20, 7);
    enable = 1'b1;
    wait_load(20, n);
    checkOutput("fl_first_latency", 32'(n), 32'd10);
    checkOutput("fl_code_20", 32'(code), 32'd20);
    wait_load(20, n);
    checkOutput("fl_gap", 32'(n), 32'd8);
    checkOutput("fl_code_21", 32'(code), 32'd21);
    checkOutput("fl_count_5", 32'(fifo_count), 32'd5);
    flush          = 1'b1;
    clear_underrun = 1'b1;
    step();
    flush          = 1'b0;
    clear_underrun = 1'b0;
    period         = 16'd0;
    checkOutput("fl_count_0", 32'(fifo_count), 32'd0);
    checkOutput("fl_clr_underrun", 32'(underrun), 32'd0);
    checkOutput("fl_clr_cnt", 32'(underrun_cnt), 32'd0);
    n = 0;
    do begin
      step();
      n++;
    end while (!underrun && n < 20);
    checkOutput("fl_underrun_delay", 32'(n), 32'd7);
    checkOutput("fl_underrun_cnt", 32'(underrun_cnt), 32'd1);
    checkOutput("fl_code_held", 32'(code), 32'd21);
    checkOutput("fl_state_prime", 32'(dut.state), 32'(PRIME));

    // clear_underrun coincident with a new underrun
    force_underrun(1'b0);
    checkOutput("ur_cnt_2", 32'(underrun_cnt), 32'd2);
    force_underrun(1'b1);
    checkOutput("ur_clr_coinc_flag", 32'(underrun), 32'd1);
    checkOutput("ur_clr_coinc_cnt", 32'(underrun_cnt), 32'd1);

    // Saturation: 300 more underruns
    repeat (300) force_underrun(1'b0);
    checkOutput("sat_cnt", 32'(underrun_cnt), 32'd255);
    checkOutput("sat_flag", 32'(underrun), 32'd1);

    // Enable drop mid-RUN keeps the FIFO
    enable = 1'b0;
    step();
    period = 16'd4;
    applyStimulus(40, 6);
    enable = 1'b1;
    wait_load(20, n);
    checkOutput("en_first_latency", 32'(n), 32'd6);
    checkOutput("en_code_40", 32'(code), 32'd40);
    step();
    enable = 1'b0;
    step();
    checkOutput("en_drop_idle", 32'(dut.state), 32'(IDLE));
    checkOutput("en_drop_count", 32'(fifo_count), 32'd5);
    checkOutput("en_drop_code", 32'(code), 32'd40);
    repeat (3) step();
    checkOutput("en_idle_no_pop", 32'(fifo_count), 32'd5);
    checkOutput("en_idle_no_load", 32'(code_load), 32'd0);

    // rst mid-RUN in a tick cycle: immediate clear, no code_load
    enable = 1'b1;
    step();
    step();
    checkOutput("rr_state_run", 32'(dut.state), 32'(RUN));
    repeat (3) step();
    rst = 1'b1;
    #1;
    checkOutput("rr_code_mid", 32'(code), 32'd512);
    checkOutput("rr_count_0", 32'(fifo_count), 32'd0);
    checkOutput("rr_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rr_state_idle", 32'(dut.state), 32'(IDLE));
    checkOutput("rr_underrun", 32'(underrun), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("rr_no_load", 32'(code_load), 32'd0);
    end
    enable = 1'b0;
    rst    = 1'b0;
    step();
    checkOutput("rr_post_load", 32'(code_load), 32'd0);
    checkOutput("rr_post_code", 32'(code), 32'd512);
    checkOutput("rr_post_count", 32'(fifo_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_sample_sched.md
DAC_SAMPLE_SCHED -- requirements
Module: dac_sample_sched

Interface
REQ-001 Parameter CODE_WIDTH, default 10, sets the DAC code width in bits.
REQ-002 Parameter DEPTH, default 8 (power of 2, at least 4), sets the sample FIFO entry count.
REQ-003 Parameter PERIOD_WIDTH, default 16, sets the sample-period register width.
REQ-004 Port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port enable, input, 1 bit: run playback when 1.
REQ-007 Port flush, input, 1 bit: synchronous FIFO clear.
REQ-008 Port period, input, PERIOD_WIDTH bits: clk cycles per sample.
REQ-009 Port in_data, input, CODE_WIDTH bits: sample from the CPU.
REQ-010 Port in_valid, input, 1 bit: in_data is valid.
REQ-011 Port in_ready, output, 1 bit: FIFO can accept a sample.
REQ-012 Port code, output, CODE_WIDTH bits: current DAC code.
REQ-013 Port code_load, output, 1 bit: one-cycle strobe marking that code was updated.
REQ-014 Port underrun, output, 1 bit: sticky underrun flag.
REQ-015 Port underrun_cnt, output, 8 bits: saturating underrun count.
REQ-016 Port clear_underrun, input, 1 bit: clears underrun and underrun_cnt.
REQ-017 Port fifo_count, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-018 in_ready SHALL equal the complement of full, derived from the registered count; a push occurs on in_valid && in_ready.
REQ-019 When full, a push SHALL NOT be accepted even if a pop occurs in the same cycle.
REQ-020 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the count unchanged and preserve order.
REQ-021 The tick timer SHALL count 0..P-1 and assert an internal tick when the count equals P-1, where P = max(period,1); period 0 therefore ticks every cycle.
REQ-022 period SHALL be sampled only at timer wrap and on entry to PRIME.
REQ-023 The FSM SHALL have three states: IDLE, PRIME and RUN.
REQ-024 In IDLE, the timer SHALL be held at 0, code held, and no pops made.
REQ-025 Transition IDLE->PRIME SHALL occur when enable=1.
REQ-026 In PRIME, the timer SHALL be held at 0; transition PRIME->RUN SHALL occur when fifo_count >= DEPTH/2.
REQ-027 In RUN, on tick with FIFO non-empty: pop the head, code <= head on the next edge, and code_load=1 for exactly that one cycle after the tick.
REQ-028 In RUN, on tick with FIFO empty: code holds, underrun <= 1, underrun_cnt increments (saturating at 255), state -> PRIME; there is no push-to-output bypass.
REQ-029 enable=0 SHALL force IDLE from any state on the next edge; FIFO contents are retained.
REQ-030 flush SHALL empty the FIFO next cycle and SHALL override a same-cycle push and pop; in RUN, a subsequent tick then underruns.
REQ-031 clear_underrun SHALL zero underrun and underrun_cnt; if a same-cycle underrun occurs, the result SHALL be underrun=1 and underrun_cnt=1.
REQ-032 Latency: a sample pushed into an empty FIFO in PRIME appears on code no earlier than the first tick after priming completes.

Reset
REQ-033 While rst is high: state=IDLE, FIFO empty, timer=0, code=2^(CODE_WIDTH-1) (midscale, 512 at default), code_load=0, underrun=0, underrun_cnt=0, in_ready=1, fifo_count=0.
REQ-034 rst asserted mid-playback SHALL discard all FIFO contents, with no code_load emitted.

Structure
REQ-035 Package dac_sched_pkg SHALL hold the state enum (IDLE/PRIME/RUN) and a MIDSCALE(width) constant function.
REQ-036 The FIFO SHALL be one sub-module, sample_fifo (synchronous, parameterised by WIDTH and DEPTH, with flush), exposing full, empty and count; the timer and FSM stay in the top.

Verification
REQ-037 Reset check: after rst, code=512, in_ready=1, underrun=0, fifo_count=0, state IDLE.
REQ-038 Playback: period=4, push 8 samples 1..8, enable=1 -> code_load every 4 cycles; code sequence 1,2,...,8; then underrun=1, underrun_cnt=1, code=8 held.
REQ-039 Full and period edge cases: fill 8 entries -> in_ready=0; a push during the same-cycle pop is refused; with period=0, code_load fires every cycle in RUN.
REQ-040 Flush and clear: flush mid-RUN with 5 entries -> fifo_count=0, next tick underruns; clear_underrun coincident with an underrun -> underrun_cnt=1.
REQ-041 Saturation: force 300 underruns -> underrun_cnt=255.
REQ-042 Enable and reset: enable drop mid-RUN -> IDLE with fifo_count retained; rst asserted mid-RUN -> code=512 and fifo_count=0 immediately, with no code_load pulse.
